// File: rtl/max7219_refresh_scheduler_pkg.sv
// max7219_pkg: MAX7219 register map, configuration ROM and scheduler types.
package max7219_pkg;
    localparam logic [3:0] A_NOOP       = 4'h0;
    localparam logic [3:0] A_DIGIT0     = 4'h1;
    localparam logic [3:0] A_DIGIT1     = 4'h2;
    localparam logic [3:0] A_DIGIT2     = 4'h3;
    localparam logic [3:0] A_DIGIT3     = 4'h4;
    localparam logic [3:0] A_DIGIT4     = 4'h5;
    localparam logic [3:0] A_DIGIT5     = 4'h6;
    localparam logic [3:0] A_DIGIT6     = 4'h7;
    localparam logic [3:0] A_DIGIT7     = 4'h8;
    localparam logic [3:0] A_DECODE     = 4'h9;
    localparam logic [3:0] A_INTENSITY  = 4'hA;
    localparam logic [3:0] A_SCAN_LIMIT = 4'hB;
    localparam logic [3:0] A_SHUTDOWN   = 4'hC;
    localparam logic [3:0] A_TEST       = 4'hF;

    localparam int CFG_LEN = 6;
    localparam logic [0:CFG_LEN-1][11:0] CFG_ROM = {
        {A_SHUTDOWN,   8'h00},
        {A_TEST,       8'h00},
        {A_DECODE,     8'h00},
        {A_SCAN_LIMIT, 8'h07},
        {A_INTENSITY,  8'h00},
        {A_SHUTDOWN,   8'h01}
    };

    typedef enum logic [2:0] {S_POWERUP, S_CFG, S_FRAME, S_INT, S_ROW, S_GAP} state_t;
    typedef enum logic [1:0] {K_CFG, K_INT, K_ROW} word_kind_t;

    // One device's slot of a chain word; broadcasts replicate it across every device.
    function automatic logic [15:0] cmd_word(input logic [3:0] addr, input logic [7:0] data);
        return {4'h0, addr, data};
    endfunction
endpackage

// File: rtl/max7219_refresh_scheduler_if.sv
// max7219_tx_if: valid/ready chain-word handshake between scheduler and SPI serializer.
interface max7219_tx_if #(parameter int W = 320);
    logic         tx_valid;
    logic [W-1:0] tx_data;
    logic         tx_ready;
    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/max7219_refresh_scheduler_word_builder.sv
// max7219_word_builder: maps (kind, index, snapshot, intensity) to a full chain word.
module max7219_word_builder
    import max7219_pkg::*;
#(
    parameter int NUM_DEVICES = 20
) (
    input  word_kind_t                          i_Kind,
    input  logic [2:0]                          i_Index,
    input  logic [0:7][NUM_DEVICES-1:0][7:0]    i_Snapshot,
    input  logic [3:0]                          i_Intensity,
    output logic [NUM_DEVICES*16-1:0]           o_Word
);
    logic [11:0] w_Entry;

    always_comb begin
        w_Entry = (i_Kind == K_CFG && CFG_ROM[i_Index][11:8] != A_INTENSITY) ?
                  CFG_ROM[i_Index] : {A_INTENSITY, 4'h0, i_Intensity};
        o_Word = {NUM_DEVICES{cmd_word(w_Entry[11:8], w_Entry[7:0])}};
        if (i_Kind == K_ROW)
            for (int d = 0; d < NUM_DEVICES; d++)
                o_Word[d*16 +: 16] = cmd_word(A_DIGIT0 + 4'(i_Index), i_Snapshot[i_Index][d]);
    end
endmodule

// File: rtl/max7219_refresh_scheduler.sv
// max7219_refresh_scheduler: configures a MAX7219 chain, then streams snapshot rows frame after frame.
// Define MAX7219_PERIODIC_REINIT_EN to re-broadcast the configuration every REINIT_FRAMES frames.
module max7219_refresh_scheduler
    import max7219_pkg::*;
#(
    parameter int         NUM_DEVICES          = 20,
    parameter int         POWERUP_DELAY_CLOCKS = 1200,
    parameter int         REFRESH_DELAY_CLOCKS = 1200,
    parameter logic [3:0] INIT_INTENSITY       = 4'h8
`ifdef MAX7219_PERIODIC_REINIT_EN
    , parameter int       REINIT_FRAMES        = 64
`endif
) (
    input  logic                             i_Clk,
    input  logic                             i_Rst_n,
    input  logic [0:7][NUM_DEVICES-1:0][7:0] i_Pixels,
    input  logic [3:0]                       i_Intensity,
    input  logic                             i_Intensity_Update,
    input  logic                             i_Reinit,
    max7219_tx_if.master                     tx,
    output logic                             o_Configured,
    output logic                             o_Frame_Done
);
    localparam int PU_CLKS = POWERUP_DELAY_CLOCKS > 1 ? POWERUP_DELAY_CLOCKS : 1;
    localparam int RF_CLKS = REFRESH_DELAY_CLOCKS > 1 ? REFRESH_DELAY_CLOCKS : 1;
    localparam int CNT_MAX = PU_CLKS > RF_CLKS ? PU_CLKS : RF_CLKS;
    localparam int CNT_W   = $clog2(CNT_MAX > 2 ? CNT_MAX : 2);

    state_t                           r_State;
    logic [CNT_W-1:0]                 r_Cnt;
    logic [2:0]                       r_Idx;
    logic [0:7][NUM_DEVICES-1:0][7:0] r_Snap;
    logic [3:0]                       r_Int_Val;
    logic                             r_Int_Pend;
    logic                             r_Reinit_Pend;
    logic                             r_Tx_Valid;
    logic [NUM_DEVICES*16-1:0]        r_Tx_Data;
    logic [NUM_DEVICES*16-1:0]        w_Word;
    word_kind_t                       w_Kind;
    logic                             w_Accept;
    logic                             w_Row7_Accept;
    logic                             w_Auto_Reinit;

    assign tx.tx_valid   = r_Tx_Valid;
    assign tx.tx_data    = r_Tx_Data;
    assign w_Accept      = r_Tx_Valid && tx.tx_ready;
    assign w_Row7_Accept = w_Accept && r_State == S_ROW && r_Idx == 3'd7;
    assign w_Kind        = r_State == S_ROW ? K_ROW : r_State == S_INT ? K_INT : K_CFG;

    max7219_word_builder #(.NUM_DEVICES(NUM_DEVICES)) u_builder (
        .i_Kind      (w_Kind),
        .i_Index     (r_Idx),
        .i_Snapshot  (r_Snap),
        .i_Intensity (r_Int_Val),
        .o_Word      (w_Word)
    );

`ifdef MAX7219_PERIODIC_REINIT_EN
    localparam int FC_W = $clog2(REINIT_FRAMES > 2 ? REINIT_FRAMES : 2);
    logic [FC_W-1:0] r_Frame_Cnt;
    assign w_Auto_Reinit = w_Row7_Accept && r_Frame_Cnt == FC_W'(REINIT_FRAMES - 1);
    always_ff @(posedge i_Clk or negedge i_Rst_n)
        if (!i_Rst_n)
            r_Frame_Cnt <= '0;
        else if (w_Row7_Accept)
            r_Frame_Cnt <= w_Auto_Reinit ? '0 : r_Frame_Cnt + 1'b1;
`else
    assign w_Auto_Reinit = 1'b0;
`endif

    always_ff @(posedge i_Clk or negedge i_Rst_n)
        if (!i_Rst_n) begin
            r_State       <= S_POWERUP;
            r_Cnt         <= '0;
            r_Idx         <= '0;
            r_Snap        <= '0;
            r_Int_Val     <= INIT_INTENSITY;
            r_Int_Pend    <= 1'b0;
            r_Reinit_Pend <= 1'b0;
            r_Tx_Valid    <= 1'b0;
            r_Tx_Data     <= '0;
            o_Configured  <= 1'b0;
            o_Frame_Done  <= 1'b0;
        end else begin
            o_Frame_Done <= 1'b0;
            case (r_State)
                S_POWERUP: begin
                    r_Cnt <= r_Cnt + 1'b1;
                    if (r_Cnt == CNT_W'(PU_CLKS - 1)) begin
                        r_Cnt   <= '0;
                        r_Idx   <= '0;
                        r_State <= S_CFG;
                    end
                end
                S_GAP: begin
                    r_Cnt <= r_Cnt + 1'b1;
                    if (r_Cnt == CNT_W'(RF_CLKS - 1)) begin
                        r_Cnt   <= '0;
                        r_State <= S_FRAME;
                    end
                end
                S_FRAME: begin
                    r_Snap <= i_Pixels;
                    r_Idx  <= '0;
                    if (r_Reinit_Pend) begin
                        r_Reinit_Pend <= 1'b0;
                        o_Configured  <= 1'b0;
                        r_State       <= S_CFG;
                    end else if (r_Int_Pend) begin
                        r_Int_Pend <= 1'b0;
                        r_State    <= S_INT;
                    end else
                        r_State <= S_ROW;
                end
                default: begin
                    if (!r_Tx_Valid) begin
                        r_Tx_Valid <= 1'b1;
                        r_Tx_Data  <= w_Word;
                        // A config pass carries the latest intensity, so it consumes any pending update.
                        if (r_State == S_CFG && CFG_ROM[r_Idx][11:8] == A_INTENSITY)
                            r_Int_Pend <= 1'b0;
                    end else if (tx.tx_ready) begin
                        r_Tx_Valid <= 1'b0;
                        r_Idx      <= r_State == S_INT ? 3'd0 : r_Idx + 3'd1;
                        if (r_State == S_INT)
                            r_State <= S_ROW;
                        if (r_State == S_CFG && r_Idx == 3'(CFG_LEN - 1)) begin
                            o_Configured <= 1'b1;
                            r_State      <= S_FRAME;
                        end
                        if (w_Row7_Accept) begin
                            o_Frame_Done <= 1'b1;
                            r_State      <= S_GAP;
                        end
                    end
                end
            endcase
            // Requests are applied last so a same-cycle set beats any clear above.
            if (i_Intensity_Update) begin
                r_Int_Pend <= 1'b1;
                r_Int_Val  <= i_Intensity;
            end
            if (i_Reinit || w_Auto_Reinit)
                r_Reinit_Pend <= 1'b1;
        end
endmodule
